// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller serving the IF and MEM stall-request
// interfaces over an 8-bit little-endian RAM bus. MEM wins arbitration in IDLE.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_inst_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_done_o,
  output logic [31:0] mem_rdata_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nbytes;
  logic [AW-1:0]   addr;
  logic [31:0]     wdata;
  logic [31:0]     rbuf;
  logic            owner_mem;

  logic [CW-1:0]   next_k;
  logic [AW-1:0]   next_addr;
  logic [7:0]      next_wbyte;
  logic [31:0]     merged;

  // Map a MEM access size code to its byte count.
  function automatic logic [CW-1:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = CW'(1);
      2'b01:   size_bytes = CW'(2);
      default: size_bytes = CW'(4);
    endcase
  endfunction

  // Next byte index/address/store byte, and read buffer merged with the byte
  // returning this cycle (byte cnt-1, whose address was driven last cycle).
  always_comb begin
    next_k     = cnt + CW'(1);
    next_addr  = addr + AW'(next_k);
    next_wbyte = wdata[{next_k[1:0], 3'b000} +: 8];
    merged     = rbuf;
    if (cnt != '0) begin
      merged = rbuf | (32'(ram_din_i) << {cnt - CW'(1), 3'b000});
    end
  end

  // Controller FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      nbytes      <= '0;
      addr        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      owner_mem   <= 1'b0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
      ram_a_o     <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i || if_req_i) begin
            owner_mem <= mem_req_i;
            addr      <= mem_req_i ? mem_addr_i : if_addr_i;
            nbytes    <= mem_req_i ? size_bytes(mem_size_i) : CW'(4);
            wdata     <= mem_wdata_i;
            cnt       <= '0;
            rbuf      <= '0;
            ram_a_o   <= mem_req_i ? mem_addr_i : if_addr_i;
            if (mem_req_i && mem_we_i) begin
              state      <= WRITE;
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          rbuf <= merged;
          if (cnt == nbytes) begin
            state <= DONE;
            cnt   <= '0;
            if (owner_mem) begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= merged;
            end else begin
              if_done_o <= 1'b1;
              if_inst_o <= merged;
            end
          end else begin
            cnt     <= next_k;
            ram_a_o <= (next_k == nbytes) ? '0 : next_addr;
          end
        end
        WRITE: begin
          if (cnt == nbytes - CW'(1)) begin
            state      <= DONE;
            cnt        <= '0;
            ram_a_o    <= '0;
            ram_wr_o   <= 1'b0;
            ram_dout_o <= '0;
            mem_done_o <= 1'b1;
          end else begin
            cnt        <= next_k;
            ram_a_o    <= next_addr;
            ram_dout_o <= next_wbyte;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array
// memory model and cycle-count expectations derived from the access size.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_done_o   (if_done_o),
    .if_inst_o   (if_inst_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_size_i  (mem_size_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_done_o  (mem_done_o),
    .mem_rdata_o (mem_rdata_o),
    .ram_a_o     (ram_a_o),
    .ram_wr_o    (ram_wr_o),
    .ram_dout_o  (ram_dout_o),
    .ram_din_i   (ram_din_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic int size_n(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  // RAM: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
    ram_din_i <= ram_rd(ram_a_o);
  end

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_size_i  = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
  endtask

  // One transaction; caller is at a negedge of an IDLE cycle (cycle 0).
  task automatic do_txn(input bit is_if, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string name, output logic [31:0] got);
    int n, exp_done, done_at;
    logic [31:0] exp_data, ea, sh;
    logic d, other;
    n = is_if ? 4 : size_n(size);
    exp_done = we ? n + 1 : n + 2;
    exp_data = '0;
    got = '0;
    if (!we)
      for (int k = 0; k < n; k++) exp_data = exp_data | (32'(ref_rd(addr + 32'(k))) << (8 * k));
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_addr_i = addr; mem_wdata_i = wdata;
    end
    done_at = -1;
    for (int c = 1; c <= 12 && done_at < 0; c++) begin
      @(negedge clk);
      d     = is_if ? if_done_o : mem_done_o;
      other = is_if ? mem_done_o : if_done_o;
      checks++;
      if (other !== 1'b0) begin
        errors++; $display("FAIL %s other_done c=%0d got %b exp 0", name, c, other);
      end
      if (c <= n) begin
        ea = addr + 32'(c - 1);
        sh = wdata >> (8 * (c - 1));
        checks++;
        if (ram_a_o !== ea) begin
          errors++; $display("FAIL %s ram_a c=%0d got %h exp %h", name, c, ram_a_o, ea);
        end
        checks++;
        if (ram_wr_o !== we) begin
          errors++; $display("FAIL %s ram_wr c=%0d got %b exp %b", name, c, ram_wr_o, we);
        end
        checks++;
        if (ram_dout_o !== (we ? sh[7:0] : 8'h00)) begin
          errors++; $display("FAIL %s ram_dout c=%0d got %h exp %h", name, c, ram_dout_o, we ? sh[7:0] : 8'h00);
        end
      end
      if (d === 1'b1) done_at = c;
    end
    checks++;
    if (done_at != exp_done) begin
      errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_at, exp_done);
    end
    if (done_at > 0) begin
      checks++;
      if (ram_a_o !== 32'h0 || ram_wr_o !== 1'b0) begin
        errors++; $display("FAIL %s done_bus got a=%h wr=%b exp a=0 wr=0", name, ram_a_o, ram_wr_o);
      end
      if (!we) begin
        got = is_if ? if_inst_o : mem_rdata_o;
        checks++;
        if (got !== exp_data) begin
          errors++; $display("FAIL %s rdata got %h exp %h", name, got, exp_data);
        end
      end
    end
    if (we)
      for (int k = 0; k < n; k++) begin
        sh = wdata >> (8 * k);
        ref_mem[addr + 32'(k)] = sh[7:0];
      end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (if_done_o !== 1'b0 || mem_done_o !== 1'b0) begin
      errors++; $display("FAIL %s pulse_len got if=%b mem=%b exp 0 0", name, if_done_o, mem_done_o);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (if_done_o !== 1'b0 || mem_done_o !== 1'b0 || if_inst_o !== 32'h0 || mem_rdata_o !== 32'h0 ||
        ram_a_o !== 32'h0 || ram_wr_o !== 1'b0 || ram_dout_o !== 8'h0) begin
      errors++;
      $display("FAIL %s reset_outputs got ifd=%b md=%b inst=%h rd=%h a=%h wr=%b dout=%h exp all 0",
               name, if_done_o, mem_done_o, if_inst_o, mem_rdata_o, ram_a_o, ram_wr_o, ram_dout_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_if_fetch();
    logic [31:0] got;
    logic [7:0] pat [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 4; k++) begin
      ram[32'h100 + 32'(k)] = pat[k];
      ref_mem[32'h100 + 32'(k)] = pat[k];
    end
    do_txn(1'b1, 1'b0, 2'b10, 32'h100, '0, "if_fetch", got);
    checks++;
    if (got !== 32'h00000013) begin
      errors++; $display("FAIL if_fetch_const got %h exp 00000013", got);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    do_txn(1'b0, 1'b1, 2'b10, 32'h2000, 32'hDEADBEEF, "store_word", got);
    do_txn(1'b0, 1'b0, 2'b00, 32'h2002, '0, "load_byte", got);
    checks++;
    if (got !== 32'h000000AD) begin
      errors++; $display("FAIL load_byte_const got %h exp 000000AD", got);
    end
  endtask

  task automatic test_simultaneous();
    int m_at, i_at;
    logic [31:0] exp_m, exp_i;
    exp_m = {16'h0, ref_rd(32'h3001), ref_rd(32'h3000)};
    exp_i = {ref_rd(32'h503), ref_rd(32'h502), ref_rd(32'h501), ref_rd(32'h500)};
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'h3000;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    m_at = -1; i_at = -1;
    for (int c = 1; c <= 20 && i_at < 0; c++) begin
      @(negedge clk);
      checks++;
      if (if_done_o === 1'b1 && mem_done_o === 1'b1) begin
        errors++; $display("FAIL simul_both_done c=%0d got 1 1 exp not both", c);
      end
      if (mem_done_o === 1'b1 && m_at < 0) begin
        m_at = c;
        checks++;
        if (mem_rdata_o !== exp_m) begin
          errors++; $display("FAIL simul_mem_data got %h exp %h", mem_rdata_o, exp_m);
        end
        mem_req_i = 1'b0;
      end
      if (if_done_o === 1'b1 && i_at < 0) begin
        i_at = c;
        checks++;
        if (if_inst_o !== exp_i) begin
          errors++; $display("FAIL simul_if_data got %h exp %h", if_inst_o, exp_i);
        end
      end
    end
    idle_inputs();
    checks++;
    if (m_at != 4) begin
      errors++; $display("FAIL simul_mem_cycle got %0d exp 4", m_at);
    end
    checks++;
    if (i_at != 11) begin
      errors++; $display("FAIL simul_if_cycle got %0d exp 11", i_at);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    do_txn(1'b0, 1'b0, 2'b11, 32'hFFFFFFFE, '0, "wrap_load", got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int t0;
    t0 = cyc;
    do_txn(1'b1, 1'b0, 2'b10, 32'h40, '0, "b2b_0", got);
    do_txn(1'b0, 1'b0, 2'b10, 32'h44, '0, "b2b_1", got);
    checks++;
    if (cyc - t0 != 14) begin
      errors++; $display("FAIL b2b_cycles got %0d exp 14", cyc - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic [31:0] a = 32'h6000;
    logic [31:0] wd = 32'hA1B2C3D4;
    logic [31:0] sh;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = a; mem_wdata_i = wd;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      sh = wd >> (8 * k);
      ref_mem[a + 32'(k)] = sh[7:0];
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet c=%0d got done=%b wr=%b exp 0 0", c, mem_done_o, ram_wr_o);
      end
    end
    do_txn(1'b1, 1'b0, 2'b10, a, '0, "after_reset_fetch", got);
  endtask

  task automatic test_random();
    logic [31:0] got, addr;
    bit is_if, we;
    logic [1:0] size;
    for (int i = 0; i < 40; i++) begin
      is_if = ($urandom_range(0, 2) == 0);
      we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else addr = 32'h4000 + 32'($urandom_range(0, 31));
      do_txn(is_if, we, size, addr, $urandom, "random", got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_store_load();
    test_simultaneous();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that serves as the responder on the stall-request memory interface used by the fetch and memory-access stages. It accepts word, half-word and byte requests from two clients: instruction fetch (IF) and the MEM stage. It arbitrates between them and serializes each access onto the 8-bit RAM bus, little-endian. It returns assembled read data together with a one-cycle done pulse, which the pipeline control uses to release the stall.

## Interface
- No parameters. Address width is fixed at 32 bits and RAM data width at 8 bits.
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  synchronous reset, active-high; `RstEnable` = 1'b1.
- if_req_i  in  1  IF request: 4-byte read.
- if_addr_i  in  32  IF byte address.
- if_done_o  out  1  one-cycle pulse; if_inst_o is valid in the same cycle.
- if_inst_o  out  32  fetched word, little-endian.
- mem_req_i  in  1  MEM request.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  access size: 00 = byte, 01 = half-word, 10 or 11 = word.
- mem_addr_i  in  32  MEM byte address.
- mem_wdata_i  in  32  store data; byte k is written from bits [8k+7:8k].
- mem_done_o  out  1  one-cycle pulse; mem_rdata_o is valid in the same cycle for loads.
- mem_rdata_o  out  32  load data, zero-extended. Sign extension belongs to the MEM stage.
- ram_a_o  out  32  RAM byte address.
- ram_wr_o  out  1  1 = write ram_dout_o to ram_a_o this cycle.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte. It is valid in the cycle after its address is driven on ram_a_o.

## Operation
- Byte count N: 1 for byte, 2 for half-word, 4 for word. IF requests always use N = 4.
- FSM states:
  - IDLE: sample requests.
  - READ: byte counter cnt runs 0..N; address phase and capture phase overlap.
  - WRITE: cnt runs 0..N-1.
  - DONE: pulse done for one cycle, then return to IDLE.
- Arbitration happens only in IDLE:
  - If mem_req_i = 1, the MEM request wins, including when both clients request in the same cycle.
  - Otherwise, if if_req_i = 1, the IF request is served.
  - The winning request's address, size, we and wdata are latched at the acceptance edge.
- No preemption: an accepted transaction always runs to DONE, even if the other client requests meanwhile.
- A request that loses arbitration stays pending and is served on the next IDLE cycle in which it is still asserted.
- Byte k address is latched_addr + k, computed modulo 2^32; 0xFFFFFFFF wraps to 0x00000000.
- Misaligned addresses are legal and need no special handling.
- READ:
  - ram_a_o steps through byte addresses 0..N-1 with ram_wr_o = 0.
  - Byte k is captured from ram_din_i into data bits [8k+7:8k].
  - Bits above 8N-1 are zero.
- WRITE: ram_wr_o = 1 and ram_dout_o = wdata byte k for each k; no read capture.
- DONE cycle:
  - Assert the winning client's done output.
  - Drive the assembled data on if_inst_o or mem_rdata_o, held until the next done for that port.
  - ram_a_o = 0, ram_wr_o = 0.
- Requester obligations:
  - Hold req and all request inputs stable from assertion until done.
  - Deassert req, or present a new request, in the cycle after done.
  - A req still high in the DONE cycle is ignored, because DONE is not IDLE.
- Outside an active address phase (IDLE and DONE): ram_a_o = 0, ram_wr_o = 0, ram_dout_o = 0.

## Timing
- Cycle 0 is the cycle in which the request is sampled in IDLE; cycle numbers below count from there.
- Read of N bytes:
  - Byte k address on ram_a_o in cycle k+1.
  - Byte k data sampled at the end of cycle k+2.
  - Done in cycle N+2: word read in cycle 6, half-word in cycle 4, byte in cycle 3.
- Write of N bytes:
  - Byte k on the bus with ram_wr_o = 1 in cycle k+1.
  - Done in cycle N+1: word write in cycle 5, half-word in cycle 3, byte in cycle 2.
- Back-to-back: the earliest next acceptance is in the cycle after DONE. A word read therefore costs 7 cycles per access.
- Reset values (any cycle in which rst = 1, including mid-transaction):
  - State = IDLE, cnt = 0.
  - if_done_o = 0, mem_done_o = 0.
  - if_inst_o = 0, mem_rdata_o = 0.
  - ram_a_o = 0, ram_wr_o = 0, ram_dout_o = 0.
- Reset mid-transaction aborts the access: no done pulse is produced, and partial writes already issued are not undone.
- Done outputs are never high for more than one consecutive cycle. if_done_o and mem_done_o are never high together.

## Test plan
- IF word fetch:
  - Stimulus: RAM bytes 0x100..0x103 = 13 00 00 00; if_req_i = 1 with if_addr_i = 0x100.
  - Required: ram_a_o = 0x100..0x103 in cycles 1..4; if_done_o = 1 in cycle 6 only; if_inst_o = 0x00000013.
- MEM store word then load byte:
  - Store: mem_we_i = 1, size word, mem_addr_i = 0x2000, mem_wdata_i = 0xDEADBEEF.
    - Required: EF, BE, AD, DE written to 0x2000..0x2003 with ram_wr_o = 1 in cycles 1..4; mem_done_o in cycle 5.
  - Load: byte load from 0x2002.
    - Required: mem_rdata_o = 0x000000AD with done in cycle 3.
- Simultaneous requests:
  - Stimulus: if_req_i and mem_req_i both rise in the same IDLE cycle; the MEM request is a half-word load from 0x3000.
  - Required: MEM is served first, with mem_done_o in cycle 4. The IF request is accepted in the cycle after DONE, and if_done_o follows 6 cycles after that acceptance.
- Address wrap:
  - Stimulus: word load at 0xFFFFFFFE.
  - Required: ram_a_o sequence is FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-operation:
  - Stimulus: assert rst in cycle 3 of a word store.
  - Required: all outputs take their reset values the following cycle; no mem_done_o; no further ram_wr_o. A new IF request issued after reset completes normally.
